// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: checks the sync/blank geometry of a VGA output bus.
// VGA_CLK is treated as data and sampled in the Clk_50MHz domain; every
// rising edge of it is one pixel strobe. Sync periods, sync widths and
// blanking geometry are measured and compared against the parameters,
// giving a lock indication plus sticky error flags.
// Optional per-frame RGB checksum: define VGA_MON_CHECKSUM_EN.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        Clk_50MHz,
  input  logic        Reset,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  Red,
  input  logic [7:0]  Green,
  input  logic [7:0]  Blue,
  input  logic        Clr_Err,
  output logic        Locked,
  output logic        Err_Hsync,
  output logic        Err_Vsync,
  output logic        Err_Blank,
  output logic        Frame_Done,
  output logic [15:0] Frame_Count,
  output logic [10:0] Last_Pixels,
  output logic [9:0]  Last_Lines,
  output logic [31:0] Frame_Sum
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C   = 11'(H_SYNC);
  localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  V_SYNC_C   = 10'(V_SYNC);
  localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);

  function automatic logic [10:0] sat11(input logic [10:0] v);
    return (v == '1) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  // Pixel strobe and sampled-sync edge detection
  logic vga_clk_q;
  logic hs_q, hs_d, vs_q, vs_d;
  logic pix_en, hs_fall, hs_rise, vs_fall, vs_rise;

  assign pix_en  = VGA_CLK & ~vga_clk_q;
  assign hs_fall = pix_en &  hs_q & ~VGA_HS;
  assign hs_rise = pix_en & ~hs_q &  VGA_HS;
  assign vs_fall = pix_en &  vs_q & ~VGA_VS;
  assign vs_rise = pix_en & ~vs_q &  VGA_VS;

  // Measurement counters
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] hs_low_q, hs_low_d;
  logic [10:0] act_pix_q, act_pix_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  vs_low_q, vs_low_d;
  logic [9:0]  act_lines_q, act_lines_d;
  logic [10:0] last_pix_q, last_pix_d;
  logic [9:0]  last_lines_q, last_lines_d;
  logic [9:0]  line_after, act_lines_after;

  // Control and status
  state_e      state_q, state_d;
  logic        frame_bad_q, frame_bad_d;
  logic        err_h_q, err_h_d, err_v_q, err_v_d, err_b_q, err_b_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        chk_en, h_err, v_err, b_err, any_err;

  // Counter next-state; a line end coinciding with a frame end is folded
  // into the frame totals (line_after/act_lines_after) before they clear.
  always_comb begin
    hs_d            = hs_q;
    vs_d            = vs_q;
    pix_cnt_d       = pix_cnt_q;
    hs_low_d        = hs_low_q;
    act_pix_d       = act_pix_q;
    line_cnt_d      = line_cnt_q;
    vs_low_d        = vs_low_q;
    act_lines_d     = act_lines_q;
    last_pix_d      = last_pix_q;
    last_lines_d    = last_lines_q;
    line_after      = line_cnt_q;
    act_lines_after = act_lines_q;
    if (hs_fall) begin
      line_after = sat10(line_cnt_q);
      if (act_pix_q != '0) act_lines_after = sat10(act_lines_q);
    end
    if (pix_en) begin
      hs_d = VGA_HS;
      vs_d = VGA_VS;
      if (hs_fall) begin
        pix_cnt_d  = 11'd1;
        hs_low_d   = 11'd1;
        act_pix_d  = {10'd0, VGA_BLANK_N};
        last_pix_d = pix_cnt_q;
      end else begin
        pix_cnt_d = sat11(pix_cnt_q);
        if (!VGA_HS)     hs_low_d  = sat11(hs_low_q);
        if (VGA_BLANK_N) act_pix_d = sat11(act_pix_q);
      end
      line_cnt_d  = line_after;
      act_lines_d = act_lines_after;
      if (vs_fall) begin
        line_cnt_d   = '0;
        act_lines_d  = '0;
        last_lines_d = line_after;
        vs_low_d     = {9'd0, hs_fall};
      end else if (hs_fall && !VGA_VS) begin
        vs_low_d = sat10(vs_low_q);
      end
    end
  end

  // Geometry checks, evaluated at the edges that close a measurement
  always_comb begin
    chk_en  = (state_q != SEARCH);
    h_err   = (hs_fall && (pix_cnt_q != H_TOTAL_C)) ||
              (hs_rise && (hs_low_q != H_SYNC_C));
    v_err   = (vs_fall && (line_after != V_TOTAL_C)) ||
              (vs_rise && (vs_low_q != V_SYNC_C));
    b_err   = (hs_fall && (act_pix_q != '0) && (act_pix_q != H_ACTIVE_C)) ||
              (vs_fall && (act_lines_after != V_ACTIVE_C));
    any_err = chk_en && (h_err || v_err || b_err);
  end

  // Lock FSM next-state plus sticky flags and frame bookkeeping
  always_comb begin
    state_d      = state_q;
    frame_bad_d  = vs_fall ? 1'b0 : (frame_bad_q | any_err);
    err_h_d      = Clr_Err ? 1'b0 : err_h_q;
    err_v_d      = Clr_Err ? 1'b0 : err_v_q;
    err_b_d      = Clr_Err ? 1'b0 : err_b_q;
    frame_done_d = vs_fall && chk_en;
    frame_cnt_d  = frame_cnt_q;
    if (chk_en && h_err) err_h_d = 1'b1;
    if (chk_en && v_err) err_v_d = 1'b1;
    if (chk_en && b_err) err_b_d = 1'b1;
    if (vs_fall && (state_q == LOCKED)) frame_cnt_d = frame_cnt_q + 16'd1;
    unique case (state_q)
      SEARCH:  if (vs_fall) state_d = MEASURE;
      MEASURE: if (vs_fall && !frame_bad_q && !any_err) state_d = LOCKED;
      LOCKED:  if (any_err) state_d = MEASURE;
      default: state_d = SEARCH;
    endcase
  end

  // State and measurement registers
  always_ff @(posedge Clk_50MHz or posedge Reset) begin
    if (Reset) begin
      vga_clk_q    <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      pix_cnt_q    <= '0;
      hs_low_q     <= '0;
      act_pix_q    <= '0;
      line_cnt_q   <= '0;
      vs_low_q     <= '0;
      act_lines_q  <= '0;
      last_pix_q   <= '0;
      last_lines_q <= '0;
      state_q      <= SEARCH;
      frame_bad_q  <= 1'b0;
      err_h_q      <= 1'b0;
      err_v_q      <= 1'b0;
      err_b_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vga_clk_q    <= VGA_CLK;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      pix_cnt_q    <= pix_cnt_d;
      hs_low_q     <= hs_low_d;
      act_pix_q    <= act_pix_d;
      line_cnt_q   <= line_cnt_d;
      vs_low_q     <= vs_low_d;
      act_lines_q  <= act_lines_d;
      last_pix_q   <= last_pix_d;
      last_lines_q <= last_lines_d;
      state_q      <= state_d;
      frame_bad_q  <= frame_bad_d;
      err_h_q      <= err_h_d;
      err_v_q      <= err_v_d;
      err_b_q      <= err_b_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign Locked      = (state_q == LOCKED);
  assign Err_Hsync   = err_h_q;
  assign Err_Vsync   = err_v_q;
  assign Err_Blank   = err_b_q;
  assign Frame_Done  = frame_done_q;
  assign Frame_Count = frame_cnt_q;
  assign Last_Pixels = last_pix_q;
  assign Last_Lines  = last_lines_q;

`ifdef VGA_MON_CHECKSUM_EN
  logic [31:0] acc_q, acc_d, sum_q, sum_d, rgb_sum;

  assign rgb_sum = 32'(Red) + 32'(Green) + 32'(Blue);

  // Accumulate visible pixels; a frame end snapshots the total and restarts
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (pix_en) begin
      if (VGA_BLANK_N) acc_d = acc_q + rgb_sum;
      if (vs_fall) begin
        sum_d = acc_d;
        acc_d = '0;
      end
    end
  end

  // Checksum registers
  always_ff @(posedge Clk_50MHz or posedge Reset) begin
    if (Reset) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign Frame_Sum = sum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{Red, Green, Blue};
  assign Frame_Sum  = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 20x12 raster
// (HS falls at x=14, 3 px wide; 12x8 active; VS falls at line 8, 2 lines).
module tb_vga_sync_monitor;

  localparam int HT = 20;
  localparam int NPIX = 240;

  typedef enum int {F_NONE, F_SHORT, F_VSLONG, F_BLANK, F_ACT} fault_e;

  typedef struct {
    logic        clr;
    fault_e      f;
    logic        lk, eh, ev, eb;
    int unsigned fc;
    int unsigned sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        VGA_CLK = 1'b0, VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK_N = 1'b0;
  logic [7:0]  Red = 8'd1, Green = 8'd2, Blue = 8'd3;
  logic        Clr_Err = 1'b0;
  logic        Locked, Err_Hsync, Err_Vsync, Err_Blank, Frame_Done;
  logic [15:0] Frame_Count;
  logic [10:0] Last_Pixels;
  logic [9:0]  Last_Lines;
  logic [31:0] Frame_Sum;

  int checks = 0;
  int errors = 0;
  int clr_idx = -1;
  int fd_pulses = 0;
  int fd_long = 0;
  logic fd_prev = 1'b0;
  vec_t tbl [12];

  vga_sync_monitor #(
    .H_TOTAL(20), .H_SYNC(3), .H_ACTIVE(12),
    .V_TOTAL(12), .V_SYNC(2), .V_ACTIVE(8)
  ) dut (
    .Clk_50MHz(clk), .Reset(Reset), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .Red(Red), .Green(Green),
    .Blue(Blue), .Clr_Err(Clr_Err), .Locked(Locked), .Err_Hsync(Err_Hsync),
    .Err_Vsync(Err_Vsync), .Err_Blank(Err_Blank), .Frame_Done(Frame_Done),
    .Frame_Count(Frame_Count), .Last_Pixels(Last_Pixels),
    .Last_Lines(Last_Lines), .Frame_Sum(Frame_Sum)
  );

  always #10 clk = ~clk;

  // Frame_Done pulse counter; a pulse longer than one cycle is tallied apart
  always @(negedge clk) begin
    if (Frame_Done) begin
      if (fd_prev) fd_long++;
      else fd_pulses++;
    end
    fd_prev = Frame_Done;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_sum(input int unsigned s);
`ifdef VGA_MON_CHECKSUM_EN
    return int'(s);
`else
    return 0 * int'(s);
`endif
  endfunction

  // {HS, VS, BLANK_N} for raster position (x, y) under a given fault
  function automatic logic [2:0] pix_sig(input int x, input int y, input fault_e f, input int frow);
    logic hs, vs_low, bl;
    hs     = !(x >= 14 && x < 17);
    vs_low = (y == 8 && x >= 14) || (y == 9) || (y == 10 && x < 14) ||
             (f == F_VSLONG && (y == 10 || (y == 11 && x < 14)));
    bl     = (x < 12) && (y < 8) &&
             !(f == F_BLANK && y == frow && x >= 11) && !(f == F_ACT && y == 7);
    return {hs, !vs_low, bl};
  endfunction

  task automatic drive_pix(input int x, input int y, input fault_e f, input int frow, input int idx);
    logic [2:0] s;
    s = pix_sig(x, y, f, frow);
    @(negedge clk);
    VGA_CLK = 1'b1; VGA_HS = s[2]; VGA_VS = s[1]; VGA_BLANK_N = s[0];
    Clr_Err = (idx == clr_idx);
    @(negedge clk);
    VGA_CLK = 1'b0; Clr_Err = 1'b0;
  endtask

  task automatic gen(input fault_e f, input int frow, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (!(f == F_SHORT && i / HT == frow && i % HT == HT - 1))
        drive_pix(i % HT, i / HT, f, frow, i);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); Clr_Err = 1'b1;
    @(negedge clk); Clr_Err = 1'b0;
  endtask

  initial begin
    int fd0;
    //           clr   fault     lk    eh    ev    eb    fc sum
    tbl[0]  = '{1'b0, F_NONE,   1'b1, 1'b0, 1'b0, 1'b0, 1, 576};
    tbl[1]  = '{1'b0, F_NONE,   1'b1, 1'b0, 1'b0, 1'b0, 2, 576};
    tbl[2]  = '{1'b0, F_SHORT,  1'b0, 1'b1, 1'b0, 1'b0, 2, 576};
    tbl[3]  = '{1'b0, F_NONE,   1'b1, 1'b1, 1'b0, 1'b0, 2, 576};
    tbl[4]  = '{1'b1, F_NONE,   1'b1, 1'b0, 1'b0, 1'b0, 3, 576};
    tbl[5]  = '{1'b0, F_VSLONG, 1'b0, 1'b0, 1'b1, 1'b0, 4, 576};
    tbl[6]  = '{1'b0, F_NONE,   1'b0, 1'b0, 1'b1, 1'b0, 4, 576};
    tbl[7]  = '{1'b0, F_NONE,   1'b1, 1'b0, 1'b1, 1'b0, 4, 576};
    tbl[8]  = '{1'b1, F_BLANK,  1'b0, 1'b0, 1'b0, 1'b1, 4, 570};
    tbl[9]  = '{1'b1, F_ACT,    1'b0, 1'b0, 1'b0, 1'b1, 4, 504};
    tbl[10] = '{1'b0, F_NONE,   1'b1, 1'b0, 1'b0, 1'b1, 4, 576};
    tbl[11] = '{1'b0, F_NONE,   1'b1, 1'b0, 1'b0, 1'b1, 5, 576};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst Locked", 32'(Locked), 0);
    chk("rst Err_Hsync", 32'(Err_Hsync), 0);
    chk("rst Err_Vsync", 32'(Err_Vsync), 0);
    chk("rst Err_Blank", 32'(Err_Blank), 0);
    chk("rst Frame_Done", 32'(Frame_Done), 0);
    chk("rst Frame_Count", 32'(Frame_Count), 0);
    chk("rst Last_Pixels", 32'(Last_Pixels), 0);
    chk("rst Last_Lines", 32'(Last_Lines), 0);
    chk("rst Frame_Sum", Frame_Sum, 0);
    Reset = 1'b0;

    // First frame: VS fall in SEARCH only arms measurement
    fd0 = fd_pulses;
    gen(F_NONE, 0, 0, NPIX - 1);
    chk("f0 Locked", 32'(Locked), 0);
    chk("f0 Last_Lines", 32'(Last_Lines), 9);
    chk("f0 Last_Pixels", 32'(Last_Pixels), 20);
    chk("f0 Frame_Done pulses", 32'(fd_pulses - fd0), 0);
    chk("f0 Frame_Sum", Frame_Sum, 32'(exp_sum(576)));

    // Second frame: Locked and Frame_Done appear the cycle after the VS edge
    gen(F_NONE, 0, 0, 8 * HT + 13);
    chk("pre-edge Locked", 32'(Locked), 0);
    chk("pre-edge Frame_Done", 32'(Frame_Done), 0);
    drive_pix(14, 8, F_NONE, 0, 8 * HT + 14);
    chk("edge Locked", 32'(Locked), 1);
    chk("edge Frame_Done", 32'(Frame_Done), 1);
    @(negedge clk);
    chk("post-edge Frame_Done", 32'(Frame_Done), 0);
    chk("post-edge Frame_Count", 32'(Frame_Count), 0);
    gen(F_NONE, 0, 8 * HT + 15, NPIX - 1);

    // Frame-level vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].clr) pulse_clr();
      fd0 = fd_pulses;
      gen(tbl[i].f, 3, 0, NPIX - 1);
      chk($sformatf("v%0d Locked", i), 32'(Locked), 32'(tbl[i].lk));
      chk($sformatf("v%0d Err_Hsync", i), 32'(Err_Hsync), 32'(tbl[i].eh));
      chk($sformatf("v%0d Err_Vsync", i), 32'(Err_Vsync), 32'(tbl[i].ev));
      chk($sformatf("v%0d Err_Blank", i), 32'(Err_Blank), 32'(tbl[i].eb));
      chk($sformatf("v%0d Frame_Count", i), 32'(Frame_Count), tbl[i].fc);
      chk($sformatf("v%0d Last_Pixels", i), 32'(Last_Pixels), 20);
      chk($sformatf("v%0d Last_Lines", i), 32'(Last_Lines), 12);
      chk($sformatf("v%0d Frame_Sum", i), Frame_Sum, 32'(exp_sum(tbl[i].sum)));
      chk($sformatf("v%0d Frame_Done pulses", i), 32'(fd_pulses - fd0), 1);
    end

    // Stalled pixel clock with toggling syncs: nothing moves
    gen(F_NONE, 0, 0, 99);
    repeat (200) begin
      @(negedge clk);
      VGA_HS = 1'($urandom); VGA_VS = 1'($urandom); VGA_BLANK_N = 1'($urandom);
    end
    gen(F_NONE, 0, 100, NPIX - 1);
    chk("stall Locked", 32'(Locked), 1);
    chk("stall Err_Hsync", 32'(Err_Hsync), 0);
    chk("stall Err_Vsync", 32'(Err_Vsync), 0);
    chk("stall Frame_Count", 32'(Frame_Count), 6);
    chk("stall Frame_Sum", Frame_Sum, 32'(exp_sum(576)));

    // Clr_Err on the same strobe as an Hsync error: set wins, Blank clears
    clr_idx = 4 * HT + 14;
    gen(F_SHORT, 3, 0, NPIX - 1);
    clr_idx = -1;
    chk("prio Err_Hsync", 32'(Err_Hsync), 1);
    chk("prio Err_Blank", 32'(Err_Blank), 0);
    chk("prio Locked", 32'(Locked), 0);
    chk("prio Frame_Count", 32'(Frame_Count), 6);

    // Asynchronous reset at mid-frame, then relock after two VS falls
    gen(F_NONE, 0, 0, 99);
    Reset = 1'b1;
    #1;
    chk("midrst Err_Hsync", 32'(Err_Hsync), 0);
    chk("midrst Frame_Count", 32'(Frame_Count), 0);
    chk("midrst Last_Pixels", 32'(Last_Pixels), 0);
    chk("midrst Last_Lines", 32'(Last_Lines), 0);
    chk("midrst Frame_Sum", Frame_Sum, 0);
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    fd0 = fd_pulses;
    gen(F_SHORT, 6, 100, NPIX - 1);
    chk("search Err_Hsync", 32'(Err_Hsync), 0);
    chk("search Locked", 32'(Locked), 0);
    chk("search Last_Lines", 32'(Last_Lines), 4);
    chk("search Frame_Done pulses", 32'(fd_pulses - fd0), 0);
    fd0 = fd_pulses;
    gen(F_NONE, 0, 0, NPIX - 1);
    chk("relock Locked", 32'(Locked), 1);
    chk("relock Err_Hsync", 32'(Err_Hsync), 0);
    chk("relock Frame_Count", 32'(Frame_Count), 0);
    chk("relock Frame_Done pulses", 32'(fd_pulses - fd0), 1);

    chk("Frame_Done width", 32'(fd_long), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
